uart_rx_os: RTL and testbench

Parametrised, oversampling UART receiver for the UART block. It runs entirely in the system clock domain, driven by an external oversample tick. It supports 5–9 data bits, none/even/odd parity and 1 or 2 stop bits, selected at runtime, and recovers each bit with a 3-sample majority vote. Received characters enter an internal synchronous FIFO together with per-entry error flags, and the block drives RTS from the FIFO fill level.

---
 rtl/uart_defs.sv | 30 +++
 rtl/uart_rx_fifo_sync.sv | 74 +++++++
 rtl/uart_rx_os.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared UART types: receiver parity mode, oversampling FSM states and
// per-character error flags, plus runtime configuration decoders.
package uart_defs;

   localparam int RX_DATA_W_MAX = 9;

   typedef enum logic [1:0] {NONE = 2'd0, EVEN = 2'd1, ODD = 2'd2} RxParity_t;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} RxOsState_t;

   typedef struct packed {
      logic break_e;
      logic frame_e;
      logic parity_e;
   } RxErr_t;

   function automatic RxParity_t rx_parity_decode(input logic [1:0] p);
      case (p)
         2'b01:   return EVEN;
         2'b10:   return ODD;
         default: return NONE;
      endcase
   endfunction

   // Out-of-range character lengths fall back to 8 bits.
   function automatic logic [3:0] rx_bits_decode(input logic [3:0] b);
      return (b >= 4'd5 && b <= 4'd9) ? b : 4'd8;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_sync.sv
// Single-clock receive FIFO with valid/ready pop, flush and overrun pulse.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module uart_rx_fifo_sync #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_ready,
   input  logic                     i_flush,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_valid,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_overrun
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [LW-1:0]    r_level;
   logic             r_overrun;
   logic             w_full;
   logic             w_empty;
   logic             w_rd;
   logic             w_wr;

   assign w_full  = (r_level == LW'(DEPTH));
   assign w_empty = (r_level == '0);
   assign w_rd    = ~w_empty & i_ready & ~i_flush;
   assign w_wr    = i_push & (~w_full | w_rd) & ~i_flush;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_level   <= '0;
         r_overrun <= 1'b0;
      end else if (i_flush) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_level   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + AW'(1);
         if (w_rd) r_rptr <= r_rptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
         r_overrun <= i_push & w_full & ~w_rd;
      end
   end

   // Head is forced to zero when empty so the outputs read clean after reset/flush.
   assign o_data    = w_empty ? '0 : r_mem[r_rptr];
   assign o_valid   = ~w_empty;
   assign o_full    = w_full;
   assign o_empty   = w_empty;
   assign o_level   = r_level;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchroniser, 3-sample majority vote, frame FSM.
//  state      | meaning
//  IDLE       | waiting for rx low on a tick
//  START      | verifying start bit at mid-bit, glitches return to IDLE
//  DATA       | shifting data bits LSB-first
//  PARITY     | checking parity bit
//  STOP       | voting stop bit(s), push at last stop vote
//  BREAK_WAIT | line held low after a break, waiting for rx high
module uart_rx_os
   import uart_defs::*;
#(
   parameter int OVERSAMPLE    = 16,
   parameter int DATA_W_MAX    = RX_DATA_W_MAX,
   parameter int FIFO_DEPTH    = 16,
   parameter int RTS_THRESHOLD = FIFO_DEPTH - 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          os_tick_i,
   input  logic                          rx_i,
   input  logic                          enable_i,
   input  logic [3:0]                    data_bits_i,
   input  logic [1:0]                    parity_i,
   input  logic                          stop2_i,
   input  logic                          flush_i,
   output logic [DATA_W_MAX-1:0]         rx_d_o,
   output logic [2:0]                    rx_err_o,
   output logic                          rx_d_valid_o,
   input  logic                          rx_d_ready_i,
   output logic                          rx_full_o,
   output logic                          rx_empty_o,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level_o,
   output logic                          rx_rts_n_o,
   output logic                          overrun_o,
   output logic                          busy_o
);

   localparam int SC_W = $clog2(OVERSAMPLE);
   localparam int LW   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [SC_W-1:0] SC_V0   = SC_W'(OVERSAMPLE/2 - 1);
   localparam logic [SC_W-1:0] SC_V1   = SC_W'(OVERSAMPLE/2);
   localparam logic [SC_W-1:0] SC_V2   = SC_W'(OVERSAMPLE/2 + 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);

   RxOsState_t            r_state;
   RxParity_t             r_par;
   RxErr_t                r_push_err;
   logic                  r_rx_meta, r_rx_sync;
   logic [SC_W-1:0]       r_sc;
   logic                  r_s0, r_s1;
   logic [3:0]            r_bitcnt, r_nbits;
   logic                  r_stop2, r_stop_idx;
   logic [DATA_W_MAX-1:0] r_data, r_push_data;
   logic                  r_par_acc, r_par_err, r_frame_err, r_zero;
   logic                  r_push, r_rts_n;
   logic [SC_W-1:0]       w_sc_next;
   logic                  w_vote, w_at_vote, w_at_end, w_brk;
   logic [LW-1:0]         w_level;
   logic [DATA_W_MAX+2:0] w_fifo_dout;

   assign w_sc_next = (r_sc == SC_LAST) ? '0 : r_sc + SC_W'(1);
   assign w_at_vote = (w_sc_next == SC_V2);
   assign w_at_end  = (w_sc_next == SC_LAST);
   assign w_vote    = (r_s0 & r_s1) | (r_s0 & r_rx_sync) | (r_s1 & r_rx_sync);
   // r_zero already covers the first stop bit when two stop bits are used.
   assign w_brk     = (r_stop2 && r_stop_idx) ? r_zero : (r_zero & ~w_vote);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rts_n   <= 1'b1;
      end else begin
         r_rx_meta <= rx_i;
         r_rx_sync <= r_rx_meta;
         r_rts_n   <= ~enable_i | (w_level >= LW'(RTS_THRESHOLD));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_sc        <= '0;
         r_s0        <= 1'b1;
         r_s1        <= 1'b1;
         r_bitcnt    <= '0;
         r_nbits     <= 4'd8;
         r_par       <= NONE;
         r_stop2     <= 1'b0;
         r_stop_idx  <= 1'b0;
         r_data      <= '0;
         r_par_acc   <= 1'b0;
         r_par_err   <= 1'b0;
         r_frame_err <= 1'b0;
         r_zero      <= 1'b0;
         r_push      <= 1'b0;
         r_push_data <= '0;
         r_push_err  <= '0;
      end else begin
         r_push <= 1'b0;
         if (!enable_i) begin
            r_state <= IDLE;
            r_sc    <= '0;
         end else if (os_tick_i) begin
            r_sc <= w_sc_next;
            if (w_sc_next == SC_V0) r_s0 <= r_rx_sync;
            if (w_sc_next == SC_V1) r_s1 <= r_rx_sync;
            case (r_state)
               IDLE: begin
                  r_sc <= '0;
                  if (!r_rx_sync) begin
                     r_state     <= START;
                     r_nbits     <= rx_bits_decode(data_bits_i);
                     r_par       <= rx_parity_decode(parity_i);
                     r_stop2     <= stop2_i;
                     r_stop_idx  <= 1'b0;
                     r_bitcnt    <= '0;
                     r_data      <= '0;
                     r_par_acc   <= 1'b0;
                     r_par_err   <= 1'b0;
                     r_frame_err <= 1'b0;
                     r_zero      <= 1'b1;
                  end
               end
               START: begin
                  if (w_at_vote && w_vote) r_state <= IDLE;
                  else if (w_at_end)       r_state <= DATA;
               end
               DATA: begin
                  if (w_at_vote) begin
                     r_data[r_bitcnt] <= w_vote;
                     r_par_acc        <= r_par_acc ^ w_vote;
                     if (w_vote) r_zero <= 1'b0;
                  end
                  if (w_at_end) begin
                     if (r_bitcnt == r_nbits - 4'd1) r_state <= (r_par == NONE) ? STOP : PARITY;
                     else                            r_bitcnt <= r_bitcnt + 4'd1;
                  end
               end
               PARITY: begin
                  if (w_at_vote) begin
                     r_par_err <= r_par_acc ^ w_vote ^ (r_par == ODD);
                     if (w_vote) r_zero <= 1'b0;
                  end
                  if (w_at_end) r_state <= STOP;
               end
               STOP: begin
                  if (w_at_vote) begin
                     if (r_stop2 && !r_stop_idx) begin
                        r_frame_err <= ~w_vote;
                        if (w_vote) r_zero <= 1'b0;
                     end else begin
                        r_push <= 1'b1;
                        if (w_brk) begin
                           r_push_data <= '0;
                           r_push_err  <= '{break_e: 1'b1, frame_e: 1'b1, parity_e: 1'b0};
                           r_state     <= BREAK_WAIT;
                        end else begin
                           r_push_data <= r_data;
                           r_push_err  <= '{break_e: 1'b0, frame_e: r_frame_err | ~w_vote,
                                            parity_e: r_par_err};
                           r_state     <= IDLE;
                        end
                     end
                  end else if (w_at_end) begin
                     r_stop_idx <= 1'b1;
                  end
               end
               BREAK_WAIT: if (r_rx_sync) r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   uart_rx_fifo_sync #(
      .WIDTH (DATA_W_MAX + 3),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_push    (r_push),
      .i_data    ({r_push_err, r_push_data}),
      .i_ready   (rx_d_ready_i),
      .i_flush   (flush_i),
      .o_data    (w_fifo_dout),
      .o_valid   (rx_d_valid_o),
      .o_full    (rx_full_o),
      .o_empty   (rx_empty_o),
      .o_level   (w_level),
      .o_overrun (overrun_o)
   );

   assign rx_d_o     = w_fifo_dout[DATA_W_MAX-1:0];
   assign rx_err_o   = w_fifo_dout[DATA_W_MAX+2 -: 3];
   assign rx_level_o = w_level;
   assign rx_rts_n_o = r_rts_n;
   assign busy_o     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: table of frame formats plus hand-written
// sequences for glitch, break, enable drop, FIFO full/overrun, flush and reset.
module tb_uart_rx_os;

   localparam int BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clk

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       os_tick_i = 1'b0;
   logic       rx_i = 1'b1;
   logic       enable_i = 1'b1;
   logic [3:0] data_bits_i = 4'd8;
   logic [1:0] parity_i = 2'b00;
   logic       stop2_i = 1'b0;
   logic       flush_i = 1'b0;
   logic       rx_d_ready_i = 1'b0;
   logic [8:0] rx_d_o;
   logic [2:0] rx_err_o;
   logic       rx_d_valid_o, rx_full_o, rx_empty_o, rx_rts_n_o, overrun_o, busy_o;
   logic [4:0] rx_level_o;

   int checks = 0;
   int failures = 0;
   int ovr_cnt = 0;
   int ovr_base;

   uart_rx_os #(.OVERSAMPLE(16), .DATA_W_MAX(9), .FIFO_DEPTH(16), .RTS_THRESHOLD(14)) dut (
      .clk(clk), .rst_n(rst_n), .os_tick_i(os_tick_i), .rx_i(rx_i), .enable_i(enable_i),
      .data_bits_i(data_bits_i), .parity_i(parity_i), .stop2_i(stop2_i), .flush_i(flush_i),
      .rx_d_o(rx_d_o), .rx_err_o(rx_err_o), .rx_d_valid_o(rx_d_valid_o),
      .rx_d_ready_i(rx_d_ready_i), .rx_full_o(rx_full_o), .rx_empty_o(rx_empty_o),
      .rx_level_o(rx_level_o), .rx_rts_n_o(rx_rts_n_o), .overrun_o(overrun_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            os_tick_i = (k == 3);
         end
      end
   end

   always @(negedge clk) if (overrun_o) ovr_cnt++;

   initial begin
      #1000000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "bench timeout");
   end

   typedef struct {
      logic [8:0] d;
      logic [3:0] cfg_bits;
      int         send_bits;
      logic [1:0] par;
      logic       st2;
      logic       flip;
      logic       stop_v;
      logic [8:0] exp_d;
      logic [2:0] exp_e;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      rx_i = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [8:0] d, input int nb, input logic [1:0] par,
                             input logic st2, input logic flip, input logic stop_v);
      logic p;
      p = 1'b0;
      for (int i = 0; i < nb; i++) p ^= d[i];
      if (par == 2'b10) p = ~p;
      if (flip) p = ~p;
      send_bit(1'b0);
      for (int i = 0; i < nb; i++) send_bit(d[i]);
      if (par == 2'b01 || par == 2'b10) send_bit(p);
      send_bit(stop_v);
      if (st2) send_bit(1'b1);
      send_bit(1'b1);
   endtask

   task automatic check_head(input string tag, input logic [8:0] ed, input logic [2:0] ee);
      for (int i = 0; i < 400 && !rx_d_valid_o; i++) @(negedge clk);
      chk({tag, "_valid"}, 32'(rx_d_valid_o), 32'd1);
      chk({tag, "_data"}, 32'(rx_d_o), 32'(ed));
      chk({tag, "_err"}, 32'(rx_err_o), 32'(ee));
   endtask

   task automatic pop1();
      rx_d_ready_i = 1'b1;
      @(negedge clk);
      rx_d_ready_i = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_d"}, 32'(rx_d_o), 32'd0);
      chk({tag, "_err"}, 32'(rx_err_o), 32'd0);
      chk({tag, "_valid"}, 32'(rx_d_valid_o), 32'd0);
      chk({tag, "_empty"}, 32'(rx_empty_o), 32'd1);
      chk({tag, "_full"}, 32'(rx_full_o), 32'd0);
      chk({tag, "_level"}, 32'(rx_level_o), 32'd0);
      chk({tag, "_ovr"}, 32'(overrun_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      chk({tag, "_rts"}, 32'(rx_rts_n_o), 32'd1);
   endtask

   initial begin
      //            d       cfg   n  par    st2   flip  stop  exp_d   exp_e
      vecs[0] = '{9'h0A5, 4'd8, 8, 2'b00, 1'b0, 1'b0, 1'b1, 9'h0A5, 3'b000};
      vecs[1] = '{9'h03C, 4'd7, 7, 2'b10, 1'b1, 1'b0, 1'b1, 9'h03C, 3'b000};
      vecs[2] = '{9'h03C, 4'd7, 7, 2'b10, 1'b1, 1'b1, 1'b1, 9'h03C, 3'b001};
      vecs[3] = '{9'h1FF, 4'd9, 9, 2'b01, 1'b0, 1'b0, 1'b1, 9'h1FF, 3'b000};
      vecs[4] = '{9'h0F0, 4'd9, 9, 2'b01, 1'b0, 1'b0, 1'b0, 9'h0F0, 3'b010};
      vecs[5] = '{9'h015, 4'd5, 5, 2'b00, 1'b0, 1'b0, 1'b1, 9'h015, 3'b000};
      vecs[6] = '{9'h02A, 4'd6, 6, 2'b01, 1'b1, 1'b0, 1'b1, 9'h02A, 3'b000};
      vecs[7] = '{9'h000, 4'd8, 8, 2'b10, 1'b0, 1'b0, 1'b1, 9'h000, 3'b000};
      vecs[8] = '{9'h0C3, 4'd12, 8, 2'b11, 1'b0, 1'b0, 1'b1, 9'h0C3, 3'b000};

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("rts_after_reset", 32'(rx_rts_n_o), 32'd0);

      ovr_base = ovr_cnt;
      foreach (vecs[i]) begin
         data_bits_i = vecs[i].cfg_bits;
         parity_i    = vecs[i].par;
         stop2_i     = vecs[i].st2;
         send_frame(vecs[i].d, vecs[i].send_bits, vecs[i].par, vecs[i].st2,
                    vecs[i].flip, vecs[i].stop_v);
         check_head($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_e);
         pop1();
         chk($sformatf("vec%0d_empty_after_pop", i), 32'(rx_empty_o), 32'd1);
      end
      chk("vec_no_overrun", 32'(ovr_cnt - ovr_base), 32'd0);

      // Short low pulse on the line must be rejected before the start-bit vote completes.
      data_bits_i = 4'd8; parity_i = 2'b00; stop2_i = 1'b0;
      rx_i = 1'b0;
      repeat (16) @(negedge clk);
      chk("glitch_busy_high", 32'(busy_o), 32'd1);
      repeat (4) @(negedge clk);
      rx_i = 1'b1;
      repeat (44) @(negedge clk);
      chk("glitch_busy_low", 32'(busy_o), 32'd0);
      chk("glitch_no_entry", 32'(rx_level_o), 32'd0);

      // Long break, then a normal frame.
      rx_i = 1'b0;
      repeat (30 * BIT_CLKS) @(negedge clk);
      chk("break_level", 32'(rx_level_o), 32'd1);
      chk("break_busy_wait", 32'(busy_o), 32'd1);
      check_head("break", 9'h000, 3'b110);
      rx_i = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      chk("break_release_idle", 32'(busy_o), 32'd0);
      pop1();
      send_frame(9'h05A, 8, 2'b00, 1'b0, 1'b0, 1'b1);
      check_head("after_break", 9'h05A, 3'b000);
      pop1();

      // Dropping enable mid-frame discards the partial character.
      rx_i = 1'b0;
      repeat (2 * BIT_CLKS) @(negedge clk);
      chk("en_busy", 32'(busy_o), 32'd1);
      enable_i = 1'b0;
      @(negedge clk);
      chk("en_off_idle", 32'(busy_o), 32'd0);
      chk("en_off_rts", 32'(rx_rts_n_o), 32'd1);
      rx_i = 1'b1;
      enable_i = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      chk("en_discard", 32'(rx_level_o), 32'd0);

      // Fill to full with ready low; the 17th character overruns.
      ovr_base = ovr_cnt;
      for (int i = 0; i < 17; i++) begin
         int lvl;
         send_frame(9'(8'h40 + i), 8, 2'b00, 1'b0, 1'b0, 1'b1);
         lvl = (i + 1 > 16) ? 16 : i + 1;
         chk($sformatf("fill%0d_level", i), 32'(rx_level_o), 32'(lvl));
         chk($sformatf("fill%0d_rts", i), 32'(rx_rts_n_o), (lvl >= 14) ? 32'd1 : 32'd0);
         if (i == 15) chk("fill_no_ovr_yet", 32'(ovr_cnt - ovr_base), 32'd0);
      end
      chk("fill_full", 32'(rx_full_o), 32'd1);
      chk("fill_ovr_one_pulse", 32'(ovr_cnt - ovr_base), 32'd1);
      chk("fill_head", 32'(rx_d_o), 32'h040);

      // Pop exactly in the push cycle: push is accepted, level stays 16.
      ovr_base = ovr_cnt;
      fork
         send_frame(9'h077, 8, 2'b00, 1'b0, 1'b0, 1'b1);
         begin
            int k;
            k = 0;
            while (!busy_o && k < 200) begin @(negedge clk); k++; end
            chk("simul_saw_busy", 32'(busy_o), 32'd1);
            k = 0;
            while (busy_o && k < 1000) begin @(negedge clk); k++; end
            rx_d_ready_i = 1'b1;
            @(negedge clk);
            rx_d_ready_i = 1'b0;
         end
      join
      chk("simul_level", 32'(rx_level_o), 32'd16);
      chk("simul_full", 32'(rx_full_o), 32'd1);
      chk("simul_no_ovr", 32'(ovr_cnt - ovr_base), 32'd0);
      chk("simul_head", 32'(rx_d_o), 32'h041);

      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk("flush_empty", 32'(rx_empty_o), 32'd1);
      chk("flush_level", 32'(rx_level_o), 32'd0);
      chk("flush_rts_lag", 32'(rx_rts_n_o), 32'd1);
      @(negedge clk);
      chk("flush_rts", 32'(rx_rts_n_o), 32'd0);

      // Reset in the middle of a frame with one entry stored.
      send_frame(9'h081, 8, 2'b00, 1'b0, 1'b0, 1'b1);
      chk("pre_reset_level", 32'(rx_level_o), 32'd1);
      rx_i = 1'b0;
      repeat (2 * BIT_CLKS) @(negedge clk);
      chk("pre_reset_busy", 32'(busy_o), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      rx_i = 1'b1;
      rst_n = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      chk("post_reset_idle", 32'(busy_o), 32'd0);
      chk("post_reset_empty", 32'(rx_empty_o), 32'd1);
      send_frame(9'h0E7, 8, 2'b00, 1'b0, 1'b0, 1'b1);
      check_head("post_reset", 9'h0E7, 3'b000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
